// File: rtl/multi_blink.sv
// Multi-channel LED blinker: each channel runs OFF / ON / BLINK / ONESHOT with its own
// runtime-programmable phase length, written through a single channel-addressed config port.
module multi_blink #(
   parameter int  NCH   = 4,
   parameter int  CBITS = 17,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [CBITS-1:0] cfg_period,
   output logic [NCH-1:0]   led,
   output logic [NCH-1:0]   flg,
   output logic [NCH-1:0]   busy
);

   localparam logic [1:0]       M_OFF     = 2'd0;
   localparam logic [1:0]       M_ON      = 2'd1;
   localparam logic [1:0]       M_BLINK   = 2'd2;
   localparam logic [1:0]       M_ONESHOT = 2'd3;
   localparam logic [CBITS-1:0] CNT_ONE   = CBITS'(1);

   logic [NCH-1:0]       w_wr;
   logic [2*NCH-1:0]     w_mode_flat;
   logic [NCH*CBITS-1:0] w_period_flat;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam logic [CHW-1:0] CH_ID = CHW'(i);

      logic [1:0]       r_mode, w_mode_nxt;
      logic [CBITS-1:0] r_cnt, w_cnt_nxt;
      logic [CBITS-1:0] r_period, w_period_nxt;
      logic             r_led, w_led_nxt;
      logic             r_flg, w_flg_nxt;
      logic             w_wrap;

      // Out-of-range channel numbers match no CH_ID, so such writes fall on the floor.
      assign w_wr[i] = cfg_we && (cfg_ch == CH_ID);
      assign w_wrap  = (r_cnt == r_period);

      // Next-state: a config write always beats a wrap on the same edge.
      always_comb begin
         w_mode_nxt   = r_mode;
         w_period_nxt = r_period;
         w_cnt_nxt    = r_cnt;
         w_led_nxt    = r_led;
         w_flg_nxt    = 1'b0;
         if (w_wr[i]) begin
            w_mode_nxt   = cfg_mode;
            w_period_nxt = cfg_period;
            w_cnt_nxt    = '0;
            w_led_nxt    = (cfg_mode != M_OFF);
         end else begin
            case (r_mode)
               M_OFF: begin
                  w_cnt_nxt = '0;
                  w_led_nxt = 1'b0;
               end
               M_ON: begin
                  w_cnt_nxt = '0;
                  w_led_nxt = 1'b1;
               end
               M_BLINK: begin
                  if (w_wrap) begin
                     w_cnt_nxt = '0;
                     w_led_nxt = ~r_led;
                     w_flg_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_ONE;
                  end
               end
               M_ONESHOT: begin
                  if (w_wrap) begin
                     w_cnt_nxt  = '0;
                     w_led_nxt  = 1'b0;
                     w_flg_nxt  = 1'b1;
                     w_mode_nxt = M_OFF;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_ONE;
                  end
               end
               default: begin
                  w_mode_nxt = M_OFF;
                  w_cnt_nxt  = '0;
                  w_led_nxt  = 1'b0;
               end
            endcase
         end
      end

      // State register with asynchronous reset to OFF and a full-scale period.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_mode   <= M_OFF;
            r_period <= '1;
            r_cnt    <= '0;
            r_led    <= 1'b0;
            r_flg    <= 1'b0;
         end else begin
            r_mode   <= w_mode_nxt;
            r_period <= w_period_nxt;
            r_cnt    <= w_cnt_nxt;
            r_led    <= w_led_nxt;
            r_flg    <= w_flg_nxt;
         end
      end

      assign led[i]  = r_led;
      assign flg[i]  = r_flg;
      assign busy[i] = r_mode[1];

      assign w_mode_flat[2*i +: 2]           = r_mode;
      assign w_period_flat[CBITS*i +: CBITS] = r_period;
   end

   multi_blink_chk #(.NCH(NCH), .CBITS(CBITS)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .i_wr     (w_wr),
      .i_mode   (w_mode_flat),
      .i_period (w_period_flat),
      .i_led    (led),
      .i_flg    (flg),
      .i_busy   (busy)
   );

endmodule

// Per-channel behavioural invariants of the blinker.
module multi_blink_chk #(
   parameter int NCH   = 4,
   parameter int CBITS = 17
) (
   input logic                 clk,
   input logic                 rst,
   input logic [NCH-1:0]       i_wr,
   input logic [2*NCH-1:0]     i_mode,
   input logic [NCH*CBITS-1:0] i_period,
   input logic [NCH-1:0]       i_led,
   input logic [NCH-1:0]       i_flg,
   input logic [NCH-1:0]       i_busy
);

   for (genvar i = 0; i < NCH; i++) begin : g_chk
      a_blink_gap: assert property (@(posedge clk) disable iff (rst)
         (i_flg[i] && (i_mode[2*i +: 2] == 2'd2) && (i_period[CBITS*i +: CBITS] != '0))
            |=> !i_flg[i]);

      a_flg_busy: assert property (@(posedge clk) disable iff (rst)
         i_flg[i] |-> $past(i_busy[i]));

      a_led_cause: assert property (@(posedge clk) disable iff (rst)
         (i_led[i] != $past(i_led[i])) |-> ($past(i_wr[i]) || i_flg[i]));
   end

endmodule
